irq_ctrl: RTL and testbench

- External interrupt controller: the source side of the machine-external-interrupt handshake consumed by the core's CSR unit.
- Synchronises up to 32 interrupt lines, edge-detects them into a pending register and masks them with an enable register.
- Selects the highest-priority enabled pending source, raises meip_o, and holds it until the core pulses ack_i.
- Exposes enable, pending and claim registers on a small word-addressed register port.

---
 rtl/irq_ctrl.sv | 139 +++++++++++++
 tb/tb_irq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// External interrupt controller: synchronises and edge-detects interrupt lines,
// masks them with ENABLE and drives the meip/ack handshake towards the core.
module irq_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int GAP     = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               ack_i,
    output logic               meip_o,
    output logic [4:0]         irq_id_o,
    input  logic               wen_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_REQ   = 2'd1;
    localparam logic [1:0]  ST_GAP   = 2'd2;
    localparam logic [31:0] SRC_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << NUM_IRQ) - 32'd1);
    localparam logic [3:0]  GAP_LOAD = 4'(GAP - 1);

    logic [NUM_IRQ-1:0] sync1_q, sync2_q, hist_q;
    logic [31:0] pending_q, pending_d, enable_q, enable_d;
    logic [31:0] edge_w, w1c_clr, ack_clr, active;
    logic [4:0]  claim_q, claim_d, cur_id_q, cur_id_d, first_id;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  state_q, state_d;
    logic        meip_q, meip_d;
    logic [31:0] data_q, data_d;
    logic        reg_we;

    // Source vectors are kept 32 bits wide; bits above NUM_IRQ are masked to constant 0.
    assign reg_we   = ~wen_i;
    assign edge_w   = 32'(sync2_q & ~hist_q);
    assign active   = pending_q & enable_q;
    assign w1c_clr  = (reg_we && addr_i == 2'd1) ? data_i : 32'd0;
    assign enable_d = (reg_we && addr_i == 2'd0) ? (data_i & SRC_MASK) : enable_q;

    always_comb begin
        first_id = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (active[i]) first_id = 5'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        claim_d  = claim_q;
        cnt_d    = cnt_q;
        meip_d   = meip_q;
        ack_clr  = 32'd0;
        case (state_q)
            ST_IDLE: begin
                meip_d = 1'b0;
                if (|active) begin
                    cur_id_d = first_id;
                    state_d  = ST_REQ;
                    meip_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (ack_i) begin
                    ack_clr = 32'd1 << cur_id_q;
                    claim_d = cur_id_q;
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                    meip_d  = 1'b0;
                end else if (!active[cur_id_q]) begin
                    state_d = ST_IDLE;
                    meip_d  = 1'b0;
                end
            end
            ST_GAP: begin
                meip_d = 1'b0;
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                state_d = ST_IDLE;
                meip_d  = 1'b0;
            end
        endcase
    end

    // A fresh edge beats a same-cycle W1C or ack clear.
    for (genvar gi = 0; gi < 32; gi++) begin : g_pend
        assign pending_d[gi] = SRC_MASK[gi] &
            ((pending_q[gi] & ~w1c_clr[gi] & ~ack_clr[gi]) | edge_w[gi]);
    end

    always_comb begin
        data_d = 32'd0;
        case (addr_i)
            2'd0: data_d = enable_q;
            2'd1: data_d = pending_q;
            2'd2: data_d = 32'(claim_q);
            2'd3: data_d = {24'd0, cur_id_q, state_q, meip_q};
            default: data_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            pending_q <= 32'd0;
            enable_q  <= 32'd0;
            claim_q   <= 5'd0;
            cur_id_q  <= 5'd0;
            cnt_q     <= 4'd0;
            state_q   <= ST_IDLE;
            meip_q    <= 1'b0;
            data_q    <= 32'd0;
        end else begin
            sync1_q   <= irq_i;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            claim_q   <= claim_d;
            cur_id_q  <= cur_id_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            meip_q    <= meip_d;
            data_q    <= data_d;
        end
    end

    assign meip_o   = meip_q;
    assign irq_id_o = cur_id_q;
    assign data_o   = data_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: handshake, priority, masking, collision, reset
// and level-input behaviour with hand-computed expectations.
module tb_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  irq_i;
    logic        ack_i;
    logic        meip_o;
    logic [4:0]  irq_id_o;
    logic        wen_i;
    logic [1:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_IRQ(8), .GAP(2)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .irq_i    (irq_i),
        .ack_i    (ack_i),
        .meip_o   (meip_o),
        .irq_id_o (irq_id_o),
        .wen_i    (wen_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .data_o   (data_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        wen_i  = 1'b0;
        addr_i = a;
        data_i = d;
        step();
        wen_i  = 1'b1;
        data_i = 32'd0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        addr_i = a;
        step();
        d = data_o;
    endtask

    task automatic pulse_ack();
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
    endtask

    // Waits up to max_cyc edges for meip_o; a timeout shows up as a failed check.
    task automatic wait_meip(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !meip_o; i++) step();
        check(tag, 32'(meip_o), 32'd1);
    endtask

    logic [31:0] rd;
    logic        seen_high;

    initial begin
        reset_i = 1'b0;
        irq_i   = 8'h00;
        ack_i   = 1'b0;
        wen_i   = 1'b1;
        addr_i  = 2'd0;
        data_i  = 32'd0;
        step(3);
        check("reset_meip", 32'(meip_o), 32'd0);
        check("reset_id", 32'(irq_id_o), 32'd0);
        check("reset_data", data_o, 32'd0);
        reset_i = 1'b1;
        step(2);

        // Single source
        write_reg(2'd0, 32'h0000_0001);
        irq_i[0] = 1'b1;
        wait_meip("single_meip", 5);
        check("single_id", 32'(irq_id_o), 32'd0);
        irq_i[0] = 1'b0;
        pulse_ack();
        check("single_ack_low", 32'(meip_o), 32'd0);
        read_reg(2'd1, rd);
        check("single_pending", rd, 32'h00);
        read_reg(2'd2, rd);
        check("single_claim", rd, 32'd0);
        step(4);

        // Priority and exact gap length
        write_reg(2'd0, 32'hFFFF_FFFF);
        read_reg(2'd0, rd);
        check("enable_hardwired", rd, 32'h0000_00FF);
        irq_i = 8'h24;
        wait_meip("prio_meip", 6);
        check("prio_id", 32'(irq_id_o), 32'd2);
        irq_i = 8'h00;
        pulse_ack();
        check("gap_low1", 32'(meip_o), 32'd0);
        step();
        check("gap_low2", 32'(meip_o), 32'd0);
        step();
        check("idle_low3", 32'(meip_o), 32'd0);
        step();
        check("rerise_meip", 32'(meip_o), 32'd1);
        check("rerise_id", 32'(irq_id_o), 32'd5);
        read_reg(2'd2, rd);
        check("prio_claim2", rd, 32'd2);
        pulse_ack();
        read_reg(2'd1, rd);
        check("prio_pending", rd, 32'h00);
        read_reg(2'd2, rd);
        check("prio_claim5", rd, 32'd5);
        step(4);

        // Masking and withdraw by W1C
        write_reg(2'd0, 32'h0000_0000);
        irq_i[3] = 1'b1;
        step(2);
        irq_i[3] = 1'b0;
        step(4);
        check("mask_meip_low", 32'(meip_o), 32'd0);
        read_reg(2'd1, rd);
        check("mask_pending", rd, 32'h08);
        write_reg(2'd0, 32'h0000_0008);
        wait_meip("unmask_meip", 3);
        check("unmask_id", 32'(irq_id_o), 32'd3);
        write_reg(2'd1, 32'h0000_0008);
        step(2);
        check("withdraw_meip", 32'(meip_o), 32'd0);
        read_reg(2'd3, rd);
        check("withdraw_status", rd, 32'h18);
        read_reg(2'd1, rd);
        check("withdraw_pending", rd, 32'h00);

        // Collision: new edge of source 1 lands on the ack edge
        write_reg(2'd0, 32'h0000_0002);
        irq_i[1] = 1'b1;
        wait_meip("coll_meip", 6);
        check("coll_id", 32'(irq_id_o), 32'd1);
        irq_i[1] = 1'b0;
        step(4);
        irq_i[1] = 1'b1;
        step(2);
        pulse_ack();
        check("coll_ack_low", 32'(meip_o), 32'd0);
        read_reg(2'd1, rd);
        check("coll_pending", rd, 32'h02);
        wait_meip("coll_rerise", 6);
        check("coll_reid", 32'(irq_id_o), 32'd1);
        irq_i[1] = 1'b0;
        pulse_ack();
        step(4);

        // Stray ack in IDLE
        pulse_ack();
        step();
        check("stray_meip", 32'(meip_o), 32'd0);
        read_reg(2'd2, rd);
        check("stray_claim", rd, 32'd1);
        read_reg(2'd3, rd);
        check("stray_status", rd, 32'h08);
        read_reg(2'd1, rd);
        check("stray_pending", rd, 32'h00);

        // Reset while requesting
        irq_i[1] = 1'b1;
        wait_meip("mid_meip", 6);
        reset_i = 1'b0;
        #1;
        check("mid_reset_meip", 32'(meip_o), 32'd0);
        irq_i = 8'h00;
        step(2);
        reset_i = 1'b1;
        read_reg(2'd0, rd);
        check("post_rst_enable", rd, 32'd0);
        read_reg(2'd1, rd);
        check("post_rst_pending", rd, 32'd0);
        read_reg(2'd2, rd);
        check("post_rst_claim", rd, 32'd0);
        read_reg(2'd3, rd);
        check("post_rst_status", rd, 32'd0);

        // Level input held high
        write_reg(2'd0, 32'h0000_0010);
        irq_i[4] = 1'b1;
        wait_meip("level_meip", 6);
        check("level_id", 32'(irq_id_o), 32'd4);
        pulse_ack();
        seen_high = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (meip_o) seen_high = 1'b1;
        end
        check("level_no_repeat", 32'(seen_high), 32'd0);
        read_reg(2'd1, rd);
        check("level_pending", rd, 32'h00);
        irq_i[4] = 1'b0;
        step(4);
        irq_i[4] = 1'b1;
        wait_meip("level_second", 6);
        check("level_second_id", 32'(irq_id_o), 32'd4);
        irq_i[4] = 1'b0;
        pulse_ack();
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
